// File: rtl/unidade_controle.sv
// Multi-cycle control unit feeding the ULA: latches an instruction in T0 and
// sequences the datapath strobes through T1..T3.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   T0    | idle/fetch; IR loads from DIN when Run is high
//   T1    | MV/MVI/NOP execute and finish; ALU ops load A with Rx
//   T2    | ALU ops: Ry on bus, ULA result captured in G
//   T3    | ALU ops: G written back to Rx
module unidade_controle #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  run_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  ir_in_o,
  output logic [7:0]            r_out_o,
  output logic [7:0]            r_in_o,
  output logic                  din_out_o,
  output logic                  g_out_o,
  output logic                  a_in_o,
  output logic                  g_in_o,
  output logic [3:0]            operacao_o,
  output logic                  done_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;

  logic [3:0] opcode;
  logic [2:0] rx, ry;
  logic [7:0] rx_oh, ry_oh;
  logic       is_alu;
  logic       unused_ir_bits;

  assign opcode = ir_q[DATA_WIDTH-1 -: 4];
  assign rx     = ir_q[DATA_WIDTH-5 -: 3];
  assign ry     = ir_q[DATA_WIDTH-8 -: 3];
  assign rx_oh  = 8'b0000_0001 << rx;
  assign ry_oh  = 8'b0000_0001 << ry;
  assign is_alu = opcode inside {[4'd5:4'd10]};

  assign unused_ir_bits = ^ir_q[DATA_WIDTH-11:0];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_in_o    = 1'b0;
    r_out_o    = 8'b0;
    r_in_o     = 8'b0;
    din_out_o  = 1'b0;
    g_out_o    = 1'b0;
    a_in_o     = 1'b0;
    g_in_o     = 1'b0;
    operacao_o = 4'b0000;
    done_o     = 1'b0;

    case (state_q)
      T0: begin
        // Run is combinational into IRin, so mask it while reset is held.
        if (run_i && !reset_i) begin
          ir_in_o = 1'b1;
          ir_d    = din_i;
          state_d = T1;
        end
      end
      T1: begin
        if (opcode == OP_MV) begin
          r_out_o = ry_oh;
          r_in_o  = rx_oh;
          done_o  = 1'b1;
          state_d = T0;
        end else if (opcode == OP_MVI) begin
          din_out_o = 1'b1;
          r_in_o    = rx_oh;
          done_o    = 1'b1;
          state_d   = T0;
        end else if (is_alu) begin
          r_out_o = rx_oh;
          a_in_o  = 1'b1;
          state_d = T2;
        end else begin
          done_o  = 1'b1;
          state_d = T0;
        end
      end
      T2: begin
        r_out_o    = ry_oh;
        g_in_o     = 1'b1;
        operacao_o = opcode;
        state_d    = T3;
      end
      T3: begin
        g_out_o = 1'b1;
        r_in_o  = rx_oh;
        done_o  = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  assign busy_o = (state_q != T0);

endmodule
